// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU status-flag stage.
//   FLAG_N/Z/C/V - bit positions of each flag inside alu_flags_t
//   alu_flags_t  - packed {N, Z, C, V} flag vector
package alu_pkg;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef logic [3:0] alu_flags_t;

endpackage

// File: rtl/and_tree.sv
// and_tree: W-input AND reduction.
//   din_i  [w-1:0] - bits to reduce
//   y_o            - 1 when every bit of din_i is 1
module and_tree #(
    parameter int w = 8
) (
    input  logic [w-1:0] din_i,
    output logic         y_o
);

    assign y_o = &din_i;

endmodule

// File: rtl/flag_calc.sv
// flag_calc: combinational N/Z/C/V derivation for one ALU result.
//   res_i       - ALU result
//   a_msb_i     - operand A sign bit
//   b_msb_i     - operand B sign bit before any subtract inversion
//   cout_i      - adder carry-out (not-borrow on subtract)
//   op_arith_i  - 1 for add/sub, 0 for logic/shift
//   op_sub_i    - 1 for subtract (only meaningful with op_arith_i)
//   c_hold_i    - C of the last arithmetic op, reused by logic ops
//   v_hold_i    - V of the last arithmetic op, reused by logic ops
//   flags_o     - {N, Z, C, V}
module flag_calc
    import alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] res_i,
    input  logic         a_msb_i,
    input  logic         b_msb_i,
    input  logic         cout_i,
    input  logic         op_arith_i,
    input  logic         op_sub_i,
    input  logic         c_hold_i,
    input  logic         v_hold_i,
    output alu_flags_t   flags_o
);

    logic [W-1:0] res_n;
    logic         zero;
    logic         sign_flip;
    logic         ovf;

    // Zero detect: all bits of the inverted result are 1 exactly when res is 0.
    assign res_n = ~res_i;

    and_tree #(.w(W)) u_zero (
        .din_i (res_n),
        .y_o   (zero)
    );

    // Overflow needs the result sign to differ from A. For add the operands
    // must share a sign; for subtract the raw (uninverted) B must differ.
    assign sign_flip = (res_i[W-1] != a_msb_i);
    assign ovf       = op_sub_i ? ((a_msb_i != b_msb_i) & sign_flip)
                                : ((a_msb_i == b_msb_i) & sign_flip);

    always_comb begin
        flags_o         = '0;
        flags_o[FLAG_N] = res_i[W-1];
        flags_o[FLAG_Z] = zero;
        if (op_arith_i) begin
            flags_o[FLAG_C] = cout_i;
            flags_o[FLAG_V] = ovf;
        end else begin
            flags_o[FLAG_C] = c_hold_i;
            flags_o[FLAG_V] = v_hold_i;
        end
    end

endmodule

// File: rtl/alu_flags.sv
// alu_flags: two-stage registered status-flag stage after the ALU.
// S1 captures the raw ALU outputs, S2 holds the result plus {N,Z,C,V}.
// Full throughput with valid/ready on both sides.
//   clk, rst_n            - clock, asynchronous active-low reset
//   in_valid / in_ready   - upstream handshake
//   res, a_msb, b_msb,
//   cout, op_arith, op_sub - ALU result and side information
//   out_valid / out_ready - downstream handshake
//   res_q                 - registered result
//   flags                 - {N, Z, C, V}
//   sticky, sticky_clr    - {C_s, V_s} accumulators and their clear
//                           (only when ALU_FLAGS_STICKY_EN is defined)
module alu_flags
    import alu_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] res,
    input  logic         a_msb,
    input  logic         b_msb,
    input  logic         cout,
    input  logic         op_arith,
    input  logic         op_sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] res_q,
    output alu_flags_t   flags
`ifdef ALU_FLAGS_STICKY_EN
    ,
    output logic [1:0]   sticky,
    input  logic         sticky_clr
`endif
);

    logic         s1_valid_q;
    logic [W-1:0] s1_res_q;
    logic         s1_a_msb_q;
    logic         s1_b_msb_q;
    logic         s1_cout_q;
    logic         s1_arith_q;
    logic         s1_sub_q;

    logic [1:0]   cv_hold_q;
    logic [1:0]   cv_hold_d;
    alu_flags_t   flags_calc;

    logic         s1_load;
    logic         s1_adv;
    logic         s2_adv;

    assign s2_adv   = !out_valid | out_ready;
    assign s1_adv   = s1_valid_q & s2_adv;
    assign in_ready = !s1_valid_q | s2_adv;
    assign s1_load  = in_valid & in_ready;

    // ---- Stage 1: capture raw ALU outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_res_q   <= '0;
            s1_a_msb_q <= 1'b0;
            s1_b_msb_q <= 1'b0;
            s1_cout_q  <= 1'b0;
            s1_arith_q <= 1'b0;
            s1_sub_q   <= 1'b0;
        end else if (s1_load) begin
            s1_valid_q <= 1'b1;
            s1_res_q   <= res;
            s1_a_msb_q <= a_msb;
            s1_b_msb_q <= b_msb;
            s1_cout_q  <= cout;
            s1_arith_q <= op_arith;
            s1_sub_q   <= op_sub;
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    flag_calc #(.W(W)) u_flag_calc (
        .res_i      (s1_res_q),
        .a_msb_i    (s1_a_msb_q),
        .b_msb_i    (s1_b_msb_q),
        .cout_i     (s1_cout_q),
        .op_arith_i (s1_arith_q),
        .op_sub_i   (s1_sub_q),
        .c_hold_i   (cv_hold_q[1]),
        .v_hold_i   (cv_hold_q[0]),
        .flags_o    (flags_calc)
    );

    // Only arithmetic ops refresh the C/V seen by later logic ops.
    assign cv_hold_d = s1_arith_q ? {flags_calc[FLAG_C], flags_calc[FLAG_V]}
                                  : cv_hold_q;

    // ---- Stage 2: result, flags and C/V hold ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            res_q     <= '0;
            flags     <= '0;
            cv_hold_q <= '0;
        end else if (s2_adv) begin
            out_valid <= s1_valid_q;
            if (s1_valid_q) begin
                res_q     <= s1_res_q;
                flags     <= flags_calc;
                cv_hold_q <= cv_hold_d;
            end
        end
    end

`ifdef ALU_FLAGS_STICKY_EN
    logic [1:0] sticky_q;
    logic [1:0] sticky_d;

    // Set has priority over clear so an event landing on a clear is kept.
    always_comb begin
        sticky_d = sticky_clr ? 2'b00 : sticky_q;
        if (s1_adv) begin
            sticky_d = sticky_d | {flags_calc[FLAG_C], flags_calc[FLAG_V]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 2'b00;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky = sticky_q;
`endif

endmodule
